prof_refine_pipe: RTL and testbench

- Parametrised successor of the affine PROF (prediction refinement with optical flow) stage. Takes one (BLK+2)x(BLK+2) window of 16-bit intermediate interpolated samples, row-streamed. Takes per-pixel scaled dMv.
- Computes spatial gradients and the clipped dI. Emits a refined BLKxBLK block one row per cycle.
- Adds bit-depth generalisation, dI clipping, output clipping, bi-pred intermediate mode and valid/ready handshakes on both sides.
- Sits between the affine interpolation filter and the weighted-prediction/recon write stage.

---
 rtl/prof_refine_pipe_pkg.sv | 45 ++++
 rtl/prof_refine_pipe_if.sv | 34 +++
 rtl/prof_refine_pipe_pixel_calc.sv | 62 ++++++
 rtl/prof_refine_pipe.sv | 163 ++++++++++++++++
 tb/tb_prof_refine_pipe.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prof_refine_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prof_pkg
// Brief    : Shared types, derived constants and helpers for the PROF stage.
// Revision : 1.0
// ============================================================================
package prof_pkg;

    localparam int BIT_DEPTH_DEF = 10;
    localparam int SAMP_W_DEF    = 16;
    localparam int MV_W_DEF      = 11;

    typedef logic signed [SAMP_W_DEF-1:0] samp_t;
    typedef logic signed [MV_W_DEF-1:0]   dmv_t;
    typedef logic signed [47:0]           wide_t;

    function automatic int grad_shift_f(input int bd);
        return (bd - 6 > 6) ? bd - 6 : 6;
    endfunction

    function automatic int di_log2_f(input int bd);
        return (bd + 1 > 13) ? bd + 1 : 13;
    endfunction

    function automatic int out_shift_f(input int bd);
        return 14 - bd;
    endfunction

    localparam int GRAD_SHIFT       = grad_shift_f(BIT_DEPTH_DEF);
    localparam int DI_LIMIT         = 1 << di_log2_f(BIT_DEPTH_DEF);
    localparam int OUT_SHIFT        = out_shift_f(BIT_DEPTH_DEF);
    localparam int IF_INTERNAL_OFFS = 8192;

    function automatic wide_t clip_s(input wide_t val, input wide_t lo, input wide_t hi);
        if (val < lo) begin
            return lo;
        end
        if (val > hi) begin
            return hi;
        end
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prof_refine_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : prof_refine_pipe_if
// Brief    : Input window-row stream and output refined-row stream bundle.
// Revision : 1.0
// ============================================================================
interface prof_refine_pipe_if #(
    parameter int BLK    = 4,
    parameter int SAMP_W = 16,
    parameter int MV_W   = 11
);
    logic                       in_valid;
    logic                       in_ready;
    logic [(BLK+2)*SAMP_W-1:0]  in_row;
    logic [BLK*BLK*MV_W-1:0]    dmv_x;
    logic [BLK*BLK*MV_W-1:0]    dmv_y;
    logic                       prof_en;
    logic                       bi_mode;
    logic                       out_valid;
    logic                       out_ready;
    logic [BLK*SAMP_W-1:0]      out_row;
    logic                       out_last;

    modport master (
        output in_valid, in_row, dmv_x, dmv_y, prof_en, bi_mode, out_ready,
        input  in_ready, out_valid, out_row, out_last
    );

    modport slave (
        input  in_valid, in_row, dmv_x, dmv_y, prof_en, bi_mode, out_ready,
        output in_ready, out_valid, out_row, out_last
    );
endinterface
`default_nettype wire

// File: rtl/prof_refine_pipe_pixel_calc.sv
`default_nettype none
// ============================================================================
// Module   : prof_pixel_calc
// Brief    : Stateless per-pixel gradient, clipped dI and output formatting.
// Revision : 1.0
// ============================================================================
module prof_pixel_calc
    import prof_pkg::*;
#(
    parameter int BIT_DEPTH = 10,
    parameter int SAMP_W    = 16,
    parameter int MV_W      = 11,
    parameter int DI_W      = di_log2_f(BIT_DEPTH) + 1
) (
    input  wire logic signed [SAMP_W-1:0] i_s_c,
    input  wire logic signed [SAMP_W-1:0] i_s_l,
    input  wire logic signed [SAMP_W-1:0] i_s_r,
    input  wire logic signed [SAMP_W-1:0] i_s_u,
    input  wire logic signed [SAMP_W-1:0] i_s_d,
    input  wire logic signed [MV_W-1:0]   i_dmv_x,
    input  wire logic signed [MV_W-1:0]   i_dmv_y,
    input  wire logic                     i_prof_en,
    output logic signed [DI_W-1:0]        o_di,
    input  wire logic signed [DI_W-1:0]   i_di,
    input  wire logic                     i_bi_mode,
    output logic [SAMP_W-1:0]             o_res
);
    localparam int GS = grad_shift_f(BIT_DEPTH);
    localparam int GW = SAMP_W - GS + 1;
    localparam int PW = MV_W + GW + 1;
    localparam int SH = out_shift_f(BIT_DEPTH);

    localparam wide_t c_di_hi   = (wide_t'(1) <<< (DI_W - 1)) - 1;
    localparam wide_t c_di_lo   = -(wide_t'(1) <<< (DI_W - 1));
    localparam wide_t c_sat_hi  = (wide_t'(1) <<< (SAMP_W - 1)) - 1;
    localparam wide_t c_sat_lo  = -(wide_t'(1) <<< (SAMP_W - 1));
    localparam wide_t c_pix_max = (wide_t'(1) <<< BIT_DEPTH) - 1;
    localparam wide_t c_round   = wide_t'(IF_INTERNAL_OFFS) + (wide_t'(1) <<< (SH - 1));

    logic signed [GW-1:0] w_l_sh, w_r_sh, w_u_sh, w_d_sh;
    logic signed [GW-1:0] w_gx, w_gy;
    logic signed [PW-1:0] w_sum;
    wide_t                w_v;

    // Each sample is pre-shifted before differencing, so rounding matches the reference.
    assign w_l_sh = GW'(i_s_l >>> GS);
    assign w_r_sh = GW'(i_s_r >>> GS);
    assign w_u_sh = GW'(i_s_u >>> GS);
    assign w_d_sh = GW'(i_s_d >>> GS);

    assign w_gx  = w_r_sh - w_l_sh;
    assign w_gy  = w_d_sh - w_u_sh;
    assign w_sum = PW'(i_dmv_x) * PW'(w_gx) + PW'(i_dmv_y) * PW'(w_gy);

    assign o_di = i_prof_en ? DI_W'(clip_s(wide_t'(w_sum), c_di_lo, c_di_hi)) : '0;

    assign w_v   = wide_t'(i_s_c) + wide_t'(i_di);
    assign o_res = i_bi_mode ? SAMP_W'(clip_s(w_v, c_sat_lo, c_sat_hi))
                             : SAMP_W'(clip_s((w_v + c_round) >>> SH, '0, c_pix_max));

endmodule
`default_nettype wire

// File: rtl/prof_refine_pipe.sv
`default_nettype none
// ============================================================================
// Module   : prof_refine_pipe
// Brief    : PROF refinement: window row capture, two-stage compute, row output.
// Revision : 1.0
// ============================================================================
module prof_refine_pipe
    import prof_pkg::*;
#(
    parameter int BIT_DEPTH = 10,
    parameter int BLK       = 4,
    parameter int SAMP_W    = 16,
    parameter int MV_W      = 11
) (
    input  wire logic          clk,
    input  wire logic          rst,
    prof_refine_pipe_if.slave  bus,
    output logic               busy
);
    localparam int c_win  = BLK + 2;
    localparam int c_di_w = di_log2_f(BIT_DEPTH) + 1;
    localparam int c_rc_w = $clog2(c_win);
    localparam int c_oc_w = (BLK > 1) ? $clog2(BLK) : 1;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_calc1 = 3'd2;
    localparam logic [2:0] c_st_calc2 = 3'd3;
    localparam logic [2:0] c_st_out   = 3'd4;

    logic [2:0]                r_state;
    logic [c_win*SAMP_W-1:0]   r_win [c_win];
    logic [BLK*BLK*MV_W-1:0]   r_dmv_x;
    logic [BLK*BLK*MV_W-1:0]   r_dmv_y;
    logic                      r_prof_en;
    logic                      r_bi_mode;
    logic [c_rc_w-1:0]         r_row_cnt;
    logic [c_oc_w-1:0]         r_out_cnt;
    logic signed [c_di_w-1:0]  r_di  [BLK*BLK];
    logic [BLK*SAMP_W-1:0]     r_res [BLK];

    logic signed [c_di_w-1:0]  w_di  [BLK*BLK];
    logic [SAMP_W-1:0]         w_res [BLK*BLK];
    logic                      w_hs_in;
    logic                      w_hs_out;
    logic                      w_unused_corners;

    assign bus.in_ready  = (r_state == c_st_idle) || (r_state == c_st_load);
    assign bus.out_valid = (r_state == c_st_out);
    assign bus.out_row   = bus.out_valid ? r_res[r_out_cnt] : '0;
    assign bus.out_last  = bus.out_valid && (r_out_cnt == c_oc_w'(BLK - 1));
    assign busy          = (r_state != c_st_idle);

    assign w_hs_in  = bus.in_valid && bus.in_ready;
    assign w_hs_out = bus.out_valid && bus.out_ready;

    // The four window corners feed no pixel.
    assign w_unused_corners = ^{r_win[0][SAMP_W-1:0],
                                r_win[0][(c_win-1)*SAMP_W +: SAMP_W],
                                r_win[c_win-1][SAMP_W-1:0],
                                r_win[c_win-1][(c_win-1)*SAMP_W +: SAMP_W]};

    generate
        for (genvar i = 0; i < BLK; i++) begin : g_row
            for (genvar j = 0; j < BLK; j++) begin : g_col
                localparam int P = i * BLK + j;
                prof_pixel_calc #(
                    .BIT_DEPTH (BIT_DEPTH),
                    .SAMP_W    (SAMP_W),
                    .MV_W      (MV_W),
                    .DI_W      (c_di_w)
                ) u_pix (
                    .i_s_c     (r_win[i+1][(j+1)*SAMP_W +: SAMP_W]),
                    .i_s_l     (r_win[i+1][j*SAMP_W     +: SAMP_W]),
                    .i_s_r     (r_win[i+1][(j+2)*SAMP_W +: SAMP_W]),
                    .i_s_u     (r_win[i][(j+1)*SAMP_W   +: SAMP_W]),
                    .i_s_d     (r_win[i+2][(j+1)*SAMP_W +: SAMP_W]),
                    .i_dmv_x   (r_dmv_x[P*MV_W +: MV_W]),
                    .i_dmv_y   (r_dmv_y[P*MV_W +: MV_W]),
                    .i_prof_en (r_prof_en),
                    .o_di      (w_di[P]),
                    .i_di      (r_di[P]),
                    .i_bi_mode (r_bi_mode),
                    .o_res     (w_res[P])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_row_cnt <= '0;
            r_out_cnt <= '0;
            r_dmv_x   <= '0;
            r_dmv_y   <= '0;
            r_prof_en <= 1'b0;
            r_bi_mode <= 1'b0;
            for (int r = 0; r < c_win; r++) begin
                r_win[r] <= '0;
            end
            for (int p = 0; p < BLK*BLK; p++) begin
                r_di[p] <= '0;
            end
            for (int r = 0; r < BLK; r++) begin
                r_res[r] <= '0;
            end
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_hs_in) begin
                        r_win[0]  <= bus.in_row;
                        r_dmv_x   <= bus.dmv_x;
                        r_dmv_y   <= bus.dmv_y;
                        r_prof_en <= bus.prof_en;
                        r_bi_mode <= bus.bi_mode;
                        r_row_cnt <= c_rc_w'(1);
                        r_state   <= c_st_load;
                    end
                end
                c_st_load: begin
                    if (w_hs_in) begin
                        r_win[r_row_cnt] <= bus.in_row;
                        if (r_row_cnt == c_rc_w'(BLK + 1)) begin
                            r_row_cnt <= '0;
                            r_state   <= c_st_calc1;
                        end else begin
                            r_row_cnt <= r_row_cnt + c_rc_w'(1);
                        end
                    end
                end
                c_st_calc1: begin
                    for (int p = 0; p < BLK*BLK; p++) begin
                        r_di[p] <= w_di[p];
                    end
                    r_state <= c_st_calc2;
                end
                c_st_calc2: begin
                    for (int i = 0; i < BLK; i++) begin
                        for (int j = 0; j < BLK; j++) begin
                            r_res[i][j*SAMP_W +: SAMP_W] <= w_res[i*BLK + j];
                        end
                    end
                    r_out_cnt <= '0;
                    r_state   <= c_st_out;
                end
                c_st_out: begin
                    if (w_hs_out) begin
                        if (r_out_cnt == c_oc_w'(BLK - 1)) begin
                            r_out_cnt <= '0;
                            r_state   <= c_st_idle;
                        end else begin
                            r_out_cnt <= r_out_cnt + c_oc_w'(1);
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prof_refine_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_prof_refine_pipe
// Brief    : Directed self-checking bench for prof_refine_pipe (BIT_DEPTH=10, BLK=4).
// Revision : 1.0
// ============================================================================
module tb_prof_refine_pipe;
    localparam int BLK    = 4;
    localparam int SAMP_W = 16;
    localparam int MV_W   = 11;
    localparam int WIN    = BLK + 2;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [SAMP_W-1:0]          win [WIN][WIN];
    logic [BLK*BLK*MV_W-1:0]    dmvx;
    logic [BLK*BLK*MV_W-1:0]    dmvy;
    logic [BLK*SAMP_W-1:0]      exp_rows [BLK];

    prof_refine_pipe_if #(.BLK(BLK), .SAMP_W(SAMP_W), .MV_W(MV_W)) bus ();

    prof_refine_pipe #(
        .BIT_DEPTH (10),
        .BLK       (BLK),
        .SAMP_W    (SAMP_W),
        .MV_W      (MV_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BLK*SAMP_W-1:0] row4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic set_dmv(input int vx_top, input int vx_bot, input int vy);
        for (int p = 0; p < BLK*BLK; p++) begin
            dmvx[p*MV_W +: MV_W] = MV_W'((p < BLK*BLK/2) ? vx_top : vx_bot);
            dmvy[p*MV_W +: MV_W] = MV_W'(vy);
        end
    endtask

    task automatic set_cols(input int c0, input int c1, input int c2,
                            input int c3, input int c4, input int c5);
        for (int r = 0; r < WIN; r++) begin
            win[r][0] = 16'(c0); win[r][1] = 16'(c1); win[r][2] = 16'(c2);
            win[r][3] = 16'(c3); win[r][4] = 16'(c4); win[r][5] = 16'(c5);
        end
    endtask

    task automatic set_ramp(input bit vertical);
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                win[r][c] = 16'(64 * (vertical ? r : c));
            end
        end
    endtask

    // Side-band inputs are scrambled after row 0 so only row-0 values may be used.
    task automatic send_rows(input int n_rows, input logic en, input logic bi);
        int k;
        for (int r = 0; r < n_rows; r++) begin
            bus.in_valid = 1'b1;
            for (int c = 0; c < WIN; c++) begin
                bus.in_row[c*SAMP_W +: SAMP_W] = win[r][c];
            end
            if (r == 0) begin
                bus.dmv_x = dmvx;  bus.dmv_y = dmvy;
                bus.prof_en = en;  bus.bi_mode = bi;
            end else begin
                bus.dmv_x = ~dmvx; bus.dmv_y = ~dmvy;
                bus.prof_en = ~en; bus.bi_mode = ~bi;
            end
            k = 0;
            while (!bus.in_ready && k < 50) begin
                tick();
                k++;
            end
            chk($sformatf("in_ready_row%0d", r), bus.in_ready, 1);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic collect_block(input int stall_row, input bit check_lat);
        int k;
        if (check_lat) begin
            chk("lat_calc1_valid", bus.out_valid, 0);
            chk("lat_calc1_in_ready", bus.in_ready, 0);
            tick();
            chk("lat_calc2_valid", bus.out_valid, 0);
            tick();
            chk("lat_out_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        for (int r = 0; r < BLK; r++) begin
            k = 0;
            while (!bus.out_valid && k < 50) begin
                tick();
                k++;
            end
            chk($sformatf("row%0d_valid", r), bus.out_valid, 1);
            if (r == stall_row) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk($sformatf("stall%0d_row", s), bus.out_row, exp_rows[r]);
                    chk($sformatf("stall%0d_last", s), bus.out_last, (r == BLK-1));
                    chk($sformatf("stall%0d_in_ready", s), bus.in_ready, 0);
                end
                bus.out_ready = 1'b1;
            end
            chk($sformatf("row%0d_data", r), bus.out_row, exp_rows[r]);
            chk($sformatf("row%0d_last", r), bus.out_last, (r == BLK-1));
            chk($sformatf("row%0d_in_ready", r), bus.in_ready, 0);
            tick();
        end
        chk("done_valid", bus.out_valid, 0);
        chk("done_busy", busy, 0);
        chk("done_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.dmv_x     = '0;
        bus.dmv_y     = '0;
        bus.prof_en   = 1'b0;
        bus.bi_mode   = 1'b0;
        bus.out_ready = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;

        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_row", bus.out_row, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_busy", busy, 0);

        // Flat window: every pixel is the mid-level code.
        set_cols(0, 0, 0, 0, 0, 0);
        set_dmv(37, -5, 100);
        for (int r = 0; r < BLK; r++) exp_rows[r] = row4(512, 512, 512, 512);
        send_rows(WIN, 1'b1, 1'b0);
        collect_block(-1, 1'b1);

        // Horizontal ramp, refined: gx=2, dI=32.
        set_ramp(1'b0);
        set_dmv(16, 16, 0);
        for (int r = 0; r < BLK; r++) exp_rows[r] = row4(518, 522, 526, 530);
        send_rows(WIN, 1'b1, 1'b0);
        collect_block(-1, 1'b0);

        // Same ramp bypassed, with row 1 held under backpressure.
        for (int r = 0; r < BLK; r++) exp_rows[r] = row4(516, 520, 524, 528);
        send_rows(WIN, 1'b0, 1'b0);
        collect_block(1, 1'b0);

        // Vertical ramp: only the y gradient contributes.
        set_ramp(1'b1);
        set_dmv(3, 3, 16);
        exp_rows[0] = row4(518, 518, 518, 518);
        exp_rows[1] = row4(522, 522, 522, 522);
        exp_rows[2] = row4(526, 526, 526, 526);
        exp_rows[3] = row4(530, 530, 530, 530);
        send_rows(WIN, 1'b1, 1'b0);
        collect_block(-1, 1'b0);

        // dI clipping at both ends, pixel output.
        set_cols(-8192, 0, 32704, 0, 32704, 0);
        set_dmv(1023, -1024, 0);
        exp_rows[0] = row4(1023, 1023, 512, 1023);
        exp_rows[1] = row4(1023, 1023, 512, 1023);
        exp_rows[2] = row4(0, 1023, 512, 1023);
        exp_rows[3] = row4(0, 1023, 512, 1023);
        send_rows(WIN, 1'b1, 1'b0);
        collect_block(-1, 1'b0);

        // Same window, intermediate output.
        exp_rows[0] = row4(8191, 32704, 0, 32704);
        exp_rows[1] = row4(8191, 32704, 0, 32704);
        exp_rows[2] = row4(-8192, 32704, 0, 32704);
        exp_rows[3] = row4(-8192, 32704, 0, 32704);
        send_rows(WIN, 1'b1, 1'b1);
        collect_block(-1, 1'b0);

        // Reset in the middle of LOAD discards the partial block.
        set_ramp(1'b0);
        set_dmv(16, 16, 0);
        send_rows(4, 1'b1, 1'b0);
        chk("mid_load_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        for (int s = 0; s < 6; s++) begin
            tick();
            chk($sformatf("post_rst%0d_valid", s), bus.out_valid, 0);
        end
        chk("post_rst_in_ready", bus.in_ready, 1);

        set_ramp(1'b1);
        set_dmv(3, 3, 16);
        exp_rows[0] = row4(518, 518, 518, 518);
        exp_rows[1] = row4(522, 522, 522, 522);
        exp_rows[2] = row4(526, 526, 526, 526);
        exp_rows[3] = row4(530, 530, 530, 530);
        send_rows(WIN, 1'b1, 1'b0);
        collect_block(-1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
